// File: rtl/config_shift_receiver.sv
// Receiver for the 3-wire serial configuration link (enable, sclk, data).
// Synchronises the pins, shifts a WIDTH-bit word in LSB-first and commits it only on an exact bit count.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | waiting for enable to rise; sclk activity is ignored
//   SHIFT  | frame open; each sclk rise shifts one bit in and bumps cnt
//   COMMIT | frame closed; load cfg_out if cnt == WIDTH, else flag cfg_error
module config_shift_receiver #(
    parameter int unsigned      WIDTH       = 33,
    parameter logic [WIDTH-1:0] RESET_CFG   = '0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_in,
    input  logic             sclk_in,
    input  logic             data_in,
    output logic [WIDTH-1:0] cfg_out,
    output logic             cfg_valid,
    output logic             cfg_error,
    output logic             busy
);

    localparam int unsigned   CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   en_d;
    logic                   sclk_d;
    logic                   en_s;
    logic                   sclk_s;
    logic                   dat_s;
    logic                   en_rise;
    logic                   sclk_rise;
    logic [WIDTH-1:0]       sr;
    logic [CW-1:0]          cnt;

    // All three pins share one depth so dat_s stays aligned with sclk_s.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_sync   <= '0;
            sclk_sync <= '0;
            dat_sync  <= '0;
            en_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            en_sync   <= {en_sync[SYNC_STAGES-2:0], enable_in};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], data_in};
            en_d      <= en_s;
            sclk_d    <= sclk_s;
        end
    end

    assign en_s      = en_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign en_rise   = en_s & ~en_d;
    assign sclk_rise = sclk_s & ~sclk_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            cfg_out   <= RESET_CFG;
            cfg_valid <= 1'b0;
            cfg_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_rise) begin
                        cnt       <= '0;
                        cfg_error <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A bit arriving alongside the enable fall still belongs to this frame.
                    if (sclk_rise) begin
                        sr <= {dat_s, sr[WIDTH-1:1]};
                        if (cnt != CNT_SAT) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    if (!en_s) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (cnt == CNT_FULL) begin
                        cfg_out   <= sr;
                        cfg_valid <= 1'b1;
                    end else begin
                        cfg_error <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_shift_receiver.sv
// Testbench for config_shift_receiver: scenario tasks driving the serial link, checked against a bit-queue model.
module tb_config_shift_receiver;

    localparam int          W         = 33;
    localparam logic [32:0] RST_CFG   = 33'h1_5A5A_0F0F;
    localparam logic [7:0]  VMASK_HIT = 8'b0000_1000;

    logic          clk;
    logic          reset;
    logic          enable_in;
    logic          sclk_in;
    logic          data_in;
    logic [W-1:0]  cfg_out;
    logic          cfg_valid;
    logic          cfg_error;
    logic          busy;

    int errors;
    int checks;

    logic [W-1:0] exp_cfg;
    logic         exp_err;

    config_shift_receiver #(
        .WIDTH      (W),
        .RESET_CFG  (RST_CFG),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable_in(enable_in),
        .sclk_in  (sclk_in),
        .data_in  (data_in),
        .cfg_out  (cfg_out),
        .cfg_valid(cfg_valid),
        .cfg_error(cfg_error),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a frame is a list of bits; it commits only if exactly W arrived,
    // and bit i of the word is the i-th bit sent.
    task automatic model_frame(input logic [63:0] bits, input int n);
        bit q[$];
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) q.push_back(bits[i]);
        if (q.size() == W) begin
            w = '0;
            for (int i = 0; i < W; i++) w[i] = q[i];
            exp_cfg = w;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Sends n bits at sclk period 2 clk; vmask[k] is cfg_valid after edge k,
    // edge 0 being the first edge that samples enable low.
    task automatic drive_frame(input logic [63:0] bits, input int n, input bit last_on_fall,
                               output logic [7:0] vmask);
        enable_in = 1'b1;
        sclk_in   = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            data_in = bits[i];
            tick(1);
            sclk_in = 1'b1;
            if (last_on_fall && i == n - 1) begin
                enable_in = 1'b0;
            end else begin
                tick(1);
                sclk_in = 1'b0;
            end
        end
        if (!last_on_fall) begin
            tick(1);
            enable_in = 1'b0;
        end
        vmask = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            vmask[k] = cfg_valid;
            if (k == 0) sclk_in = 1'b0;
        end
        data_in = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable_in = 1'b0; sclk_in = 1'b0; data_in = 1'b0;
        tick(3);
        checks++;
        if (cfg_out !== RST_CFG) begin
            errors++; $display("FAIL reset_cfg_out: got %h want %h", cfg_out, RST_CFG);
        end
        checks++;
        if ({cfg_valid, cfg_error, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got v/e/b=%b%b%b want 000", cfg_valid, cfg_error, busy);
        end
        reset = 1'b0;
        tick(2);
        exp_cfg = RST_CFG;
        exp_err = 1'b0;
    endtask

    task automatic test_nominal;
        logic [7:0] vm;
        model_frame(64'h0_03CF_10404, W);
        drive_frame(64'h0_03CF_10404, W, 1'b0, vm);
        checks++;
        if (vm !== VMASK_HIT) begin errors++; $display("FAIL nominal_valid_timing: got %b want %b", vm, VMASK_HIT); end
        checks++;
        if (cfg_out !== 33'h0_3CF1_0404) begin errors++; $display("FAIL nominal_cfg_out: got %h want %h", cfg_out, 33'h0_3CF1_0404); end
        checks++;
        if (cfg_error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL nominal_err_busy: got e=%b b=%b want 0 0", cfg_error, busy);
        end
    endtask

    task automatic test_short_frame;
        logic [7:0] vm;
        model_frame(64'h1_FFFF_FFFF, 32);
        drive_frame(64'h1_FFFF_FFFF, 32, 1'b0, vm);
        checks++;
        if (vm !== 8'h00) begin errors++; $display("FAIL short_no_valid: got %b want 00000000", vm); end
        checks++;
        if (cfg_error !== 1'b1) begin errors++; $display("FAIL short_error: got %b want 1", cfg_error); end
        checks++;
        if (cfg_out !== 33'h0_3CF1_0404) begin errors++; $display("FAIL short_cfg_kept: got %h want %h", cfg_out, 33'h0_3CF1_0404); end
        enable_in = 1'b1;
        tick(4);
        checks++;
        if (cfg_error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL short_err_clear_at_start: got e=%b b=%b want 0 1", cfg_error, busy);
        end
        model_frame(64'h1_2345_6789, W);
        drive_frame(64'h1_2345_6789, W, 1'b0, vm);
        checks++;
        if (vm !== VMASK_HIT || cfg_out !== 33'h1_2345_6789) begin
            errors++; $display("FAIL short_recover: got vm=%b out=%h want %b %h", vm, cfg_out, VMASK_HIT, 33'h1_2345_6789);
        end
    endtask

    task automatic test_long_frame;
        logic [7:0]  vm;
        logic [63:0] bits;
        bits = {$urandom, $urandom};
        model_frame(bits, 34);
        drive_frame(bits, 34, 1'b0, vm);
        checks++;
        if (vm !== 8'h00 || cfg_error !== 1'b1) begin
            errors++; $display("FAIL long_reject: got vm=%b e=%b want 00000000 1", vm, cfg_error);
        end
        checks++;
        if (cfg_out !== exp_cfg) begin errors++; $display("FAIL long_cfg_kept: got %h want %h", cfg_out, exp_cfg); end
        checks++;
        if (dut.cnt !== 6'd34) begin errors++; $display("FAIL long_cnt_saturate: got %0d want 34", dut.cnt); end
    endtask

    task automatic test_idle_noise;
        bit bad_valid;
        bit bad_busy;
        bad_valid = 1'b0;
        bad_busy  = 1'b0;
        enable_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in = i[0];
            sclk_in = 1'b0;
            @(negedge clk); if (cfg_valid) bad_valid = 1'b1; if (busy) bad_busy = 1'b1;
            tick(1);
            sclk_in = 1'b1;
            @(negedge clk); if (cfg_valid) bad_valid = 1'b1; if (busy) bad_busy = 1'b1;
            tick(1);
        end
        sclk_in = 1'b0;
        tick(4);
        checks++;
        if (bad_valid || bad_busy) begin
            errors++; $display("FAIL idle_noise_pulses: got valid_seen=%b busy_seen=%b want 0 0", bad_valid, bad_busy);
        end
        checks++;
        if (cfg_out !== exp_cfg || cfg_error !== exp_err) begin
            errors++; $display("FAIL idle_noise_state: got out=%h e=%b want %h %b", cfg_out, cfg_error, exp_cfg, exp_err);
        end
    endtask

    task automatic test_edge_timing;
        logic [7:0]  vm;
        logic [63:0] bits;
        bits = {31'd0, $urandom, 1'b1};
        model_frame(bits, W);
        drive_frame(bits, W, 1'b1, vm);
        checks++;
        if (vm !== VMASK_HIT) begin errors++; $display("FAIL edge_valid_timing: got %b want %b", vm, VMASK_HIT); end
        checks++;
        if (cfg_out !== exp_cfg || cfg_error !== 1'b0) begin
            errors++; $display("FAIL edge_cfg_out: got %h e=%b want %h 0", cfg_out, cfg_error, exp_cfg);
        end
    endtask

    task automatic test_random_frames;
        logic [7:0]  vm;
        logic [63:0] bits;
        int          n;
        int          sel;
        bit          commit;
        for (int r = 0; r < 8; r++) begin
            sel  = $urandom_range(0, 3);
            n    = (sel < 2) ? W : (sel == 2) ? $urandom_range(1, 32) : $urandom_range(34, 40);
            bits = {$urandom, $urandom};
            commit = (n == W);
            model_frame(bits, n);
            drive_frame(bits, n, 1'b0, vm);
            checks++;
            if (vm !== (commit ? VMASK_HIT : 8'h00)) begin
                errors++; $display("FAIL random_valid[%0d] n=%0d: got %b want %b", r, n, vm, commit ? VMASK_HIT : 8'h00);
            end
            checks++;
            if (cfg_out !== exp_cfg || cfg_error !== exp_err) begin
                errors++; $display("FAIL random_state[%0d] n=%0d: got %h e=%b want %h %b", r, n, cfg_out, cfg_error, exp_cfg, exp_err);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] vm;
        enable_in = 1'b1;
        tick(4);
        for (int i = 0; i < 17; i++) begin
            data_in = $urandom_range(0, 1);
            tick(1); sclk_in = 1'b1;
            tick(1); sclk_in = 1'b0;
        end
        reset = 1'b1; enable_in = 1'b0;
        tick(1);
        checks++;
        if (cfg_out !== RST_CFG || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_during: got out=%h b=%b want %h 0", cfg_out, busy, RST_CFG);
        end
        tick(2);
        reset = 1'b0;
        tick(2);
        checks++;
        if (cfg_out !== RST_CFG || cfg_error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_after: got out=%h e=%b b=%b want %h 0 0", cfg_out, cfg_error, busy, RST_CFG);
        end
        exp_cfg = RST_CFG;
        model_frame(64'h1, W);
        drive_frame(64'h1, W, 1'b0, vm);
        checks++;
        if (vm !== VMASK_HIT || cfg_out !== 33'h0_0000_0001) begin
            errors++; $display("FAIL midreset_frame: got vm=%b out=%h want %b 000000001", vm, cfg_out, VMASK_HIT);
        end
    endtask

    task automatic test_enable_through_reset;
        logic [7:0]  vm;
        logic [63:0] bits;
        enable_in = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL en_high_after_reset_starts: got busy=%b want 1", busy); end
        bits = {$urandom, $urandom};
        exp_cfg = RST_CFG;
        model_frame(bits, W);
        drive_frame(bits, W, 1'b0, vm);
        checks++;
        if (vm !== VMASK_HIT || cfg_out !== exp_cfg) begin
            errors++; $display("FAIL en_high_after_reset_commit: got vm=%b out=%h want %b %h", vm, cfg_out, VMASK_HIT, exp_cfg);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_nominal;
        test_short_frame;
        test_long_frame;
        test_idle_noise;
        test_edge_timing;
        test_random_frames;
        test_reset_midframe;
        test_enable_through_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
